trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_if.sv | 33 +++
 rtl/trap_ctrl.sv | 149 ++++++++++++++
 tb/tb_trap_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - trap request, CSR access and fetch-redirect signal bundle
interface trap_ctrl_if;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] pc_in;
    logic        boundary;
    logic        irq_ext;
    logic        irq_soft;
    logic        irq_timer;
    logic        mstatus_mie;
    logic [2:0]  mie_mask;
    logic        mret;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output exc_valid, exc_cause, exc_tval, pc_in, boundary,
               irq_ext, irq_soft, irq_timer, mstatus_mie, mie_mask, mret, csr_rdata,
        input  csr_addr, csr_we, csr_wdata, busy, redirect_valid, redirect_pc
    );

    modport slave (
        input  exc_valid, exc_cause, exc_tval, pc_in, boundary,
               irq_ext, irq_soft, irq_timer, mstatus_mie, mie_mask, mret, csr_rdata,
        output csr_addr, csr_we, csr_wdata, busy, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / mret sequencer driving CSR writes and a fetch redirect
module trap_ctrl #(
    parameter bit MTVEC_VEC_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    trap_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, RD_TVEC, RD_EPC, W_STATUS_R, REDIRECT
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] target_q, target_d;

    logic        irq_pend;
    logic [3:0]  irq_code;
    logic [31:0] status_v;
    logic [31:0] tvec_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cause_q  <= 32'h0;
            tval_q   <= 32'h0;
            epc_q    <= 32'h0;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            tval_q   <= tval_d;
            epc_q    <= epc_d;
            target_q <= target_d;
        end
    end

    // mie_mask is {meie, mtie, msie}; external beats software beats timer
    always_comb begin
        irq_pend = bus.mstatus_mie & ((bus.irq_ext & bus.mie_mask[2]) |
                                      (bus.irq_soft & bus.mie_mask[0]) |
                                      (bus.irq_timer & bus.mie_mask[1]));
        if (bus.irq_ext & bus.mie_mask[2])
            irq_code = 4'd11;
        else if (bus.irq_soft & bus.mie_mask[0])
            irq_code = 4'd3;
        else
            irq_code = 4'd7;
    end

    assign tvec_base = {bus.csr_rdata[31:2], 2'b00};
    assign bus.busy  = (state_q != IDLE);

    always_comb begin
        state_d            = state_q;
        cause_d            = cause_q;
        tval_d             = tval_q;
        epc_d              = epc_q;
        target_d           = target_q;
        status_v           = bus.csr_rdata;
        bus.csr_addr       = 12'h0;
        bus.csr_we         = 1'b0;
        bus.csr_wdata      = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        case (state_q)
            IDLE: begin
                if (bus.exc_valid) begin
                    cause_d = {28'h0, bus.exc_cause};
                    tval_d  = bus.exc_tval;
                    epc_d   = {bus.pc_in[31:2], 2'b00};
                    state_d = W_EPC;
                end else if (irq_pend && bus.boundary) begin
                    cause_d = {1'b1, 27'h0, irq_code};
                    tval_d  = 32'h0;
                    epc_d   = {bus.pc_in[31:2], 2'b00};
                    state_d = W_EPC;
                end else if (bus.mret) begin
                    state_d = RD_EPC;
                end
            end
            W_EPC: begin
                bus.csr_addr  = CSR_MEPC;
                bus.csr_we    = 1'b1;
                bus.csr_wdata = epc_q;
                state_d       = W_CAUSE;
            end
            W_CAUSE: begin
                bus.csr_addr  = CSR_MCAUSE;
                bus.csr_we    = 1'b1;
                bus.csr_wdata = cause_q;
                state_d       = W_TVAL;
            end
            W_TVAL: begin
                bus.csr_addr  = CSR_MTVAL;
                bus.csr_we    = 1'b1;
                bus.csr_wdata = tval_q;
                state_d       = W_STATUS;
            end
            W_STATUS: begin
                status_v[7]     = bus.csr_rdata[3];
                status_v[3]     = 1'b0;
                status_v[12:11] = 2'b11;
                bus.csr_addr    = CSR_MSTATUS;
                bus.csr_we      = 1'b1;
                bus.csr_wdata   = status_v;
                state_d         = RD_TVEC;
            end
            RD_TVEC: begin
                bus.csr_addr = CSR_MTVEC;
                // only interrupts are vectored; exceptions always land on the base
                if (MTVEC_VEC_EN && cause_q[31] && (bus.csr_rdata[1:0] == 2'b01))
                    target_d = tvec_base + {26'h0, cause_q[3:0], 2'b00};
                else
                    target_d = tvec_base;
                state_d = REDIRECT;
            end
            RD_EPC: begin
                bus.csr_addr = CSR_MEPC;
                target_d     = tvec_base;
                state_d      = W_STATUS_R;
            end
            W_STATUS_R: begin
                status_v[3]     = bus.csr_rdata[7];
                status_v[7]     = 1'b1;
                status_v[12:11] = 2'b11;
                bus.csr_addr    = CSR_MSTATUS;
                bus.csr_we      = 1'b1;
                bus.csr_wdata   = status_v;
                state_d         = REDIRECT;
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = target_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - table-driven scoreboard bench for trap_ctrl with a behavioural CSR file
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_ctrl_if bus();
    trap_ctrl #(.MTVEC_VEC_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    int ticks = 0;
    int redir_cnt = 0;
    int redir_tick = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        redir;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        exc_valid;
        logic [3:0]  exc_cause;
        logic [31:0] tval;
        logic [31:0] pc;
        logic [2:0]  irqs;
        logic [2:0]  mask;
        logic        mie;
        logic        mret;
        logic [31:0] st;
        logic [31:0] tvec;
        logic [31:0] epc;
        logic        is_mret;
        logic [31:0] e_cause;
        logic [31:0] e_tval;
        logic [31:0] e_epc;
        logic [31:0] e_status;
        logic [31:0] e_redir;
        int          e_lat;
    } row_t;
    row_t rows[$];

    logic        ld_en;
    logic [31:0] ld_status, ld_tvec, ld_epc;
    logic [31:0] m_status, m_tvec, m_epc, m_cause, m_tval;

    always @(posedge clk) begin
        if (ld_en) begin
            m_status <= ld_status;
            m_tvec   <= ld_tvec;
            m_epc    <= ld_epc;
        end else if (bus.csr_we) begin
            case (bus.csr_addr)
                12'h300: m_status <= bus.csr_wdata;
                12'h305: m_tvec   <= bus.csr_wdata;
                12'h341: m_epc    <= bus.csr_wdata;
                12'h342: m_cause  <= bus.csr_wdata;
                12'h343: m_tval   <= bus.csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.csr_rdata = 32'h0;
        case (bus.csr_addr)
            12'h300: bus.csr_rdata = m_status;
            12'h305: bus.csr_rdata = m_tvec;
            12'h341: bus.csr_rdata = m_epc;
            12'h342: bus.csr_rdata = m_cause;
            12'h343: bus.csr_rdata = m_tval;
            default: bus.csr_rdata = 32'h0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.exc_valid   = 1'b0;
        bus.exc_cause   = 4'h0;
        bus.exc_tval    = 32'h0;
        bus.pc_in       = 32'h0;
        bus.boundary    = 1'b0;
        bus.irq_ext     = 1'b0;
        bus.irq_soft    = 1'b0;
        bus.irq_timer   = 1'b0;
        bus.mstatus_mie = 1'b0;
        bus.mie_mask    = 3'b000;
        bus.mret        = 1'b0;
    endtask

    // Advance to the next falling edge and score whatever the DUT presents there
    task automatic tick();
        exp_t e;
        @(negedge clk);
        ticks++;
        if (!rst) begin
            if (bus.csr_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_csr_write_addr", {20'h0, bus.csr_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("csr_write_is_not_redirect", {31'h0, e.redir}, 32'h0);
                    chk("csr_addr", {20'h0, bus.csr_addr}, {20'h0, e.addr});
                    chk("csr_wdata", bus.csr_wdata, e.data);
                end
            end
            if (bus.redirect_valid) begin
                redir_cnt++;
                redir_tick = ticks;
                if (sb.size() == 0) begin
                    chk("unexpected_redirect_pc", bus.redirect_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("redirect_expected_here", {31'h0, e.redir}, 32'h1);
                    chk("redirect_pc", bus.redirect_pc, e.data);
                end
                chk("redirect_csr_quiet", {bus.csr_we, bus.csr_addr, 19'h0}, 32'h0);
                chk("redirect_wdata_zero", bus.csr_wdata, 32'h0);
            end
        end
    endtask

    function automatic row_t exc_row(input logic [3:0] cause, input logic [31:0] tval,
                                     input logic [31:0] pc, input logic [2:0] irqs,
                                     input logic [2:0] mask, input logic mie, input logic mret,
                                     input logic [31:0] st, input logic [31:0] tvec,
                                     input logic [31:0] e_status, input logic [31:0] e_redir);
        row_t r;
        r = '{exc_valid: 1'b1, exc_cause: cause, tval: tval, pc: pc, irqs: irqs, mask: mask,
              mie: mie, mret: mret, st: st, tvec: tvec, epc: 32'h0, is_mret: 1'b0,
              e_cause: {28'h0, cause}, e_tval: tval, e_epc: {pc[31:2], 2'b00},
              e_status: e_status, e_redir: e_redir, e_lat: 6};
        return r;
    endfunction

    function automatic row_t irq_row(input logic [2:0] irqs, input logic [2:0] mask,
                                     input logic [31:0] pc, input logic [31:0] st,
                                     input logic [31:0] tvec, input logic [31:0] e_cause,
                                     input logic [31:0] e_status, input logic [31:0] e_redir);
        row_t r;
        r = '{exc_valid: 1'b0, exc_cause: 4'h0, tval: 32'h0, pc: pc, irqs: irqs, mask: mask,
              mie: 1'b1, mret: 1'b0, st: st, tvec: tvec, epc: 32'h0, is_mret: 1'b0,
              e_cause: e_cause, e_tval: 32'h0, e_epc: {pc[31:2], 2'b00},
              e_status: e_status, e_redir: e_redir, e_lat: 6};
        return r;
    endfunction

    function automatic row_t mret_row(input logic [31:0] st, input logic [31:0] epc,
                                      input logic [31:0] e_status, input logic [31:0] e_redir);
        row_t r;
        r = '{exc_valid: 1'b0, exc_cause: 4'h0, tval: 32'h0, pc: 32'h0, irqs: 3'b000,
              mask: 3'b000, mie: 1'b0, mret: 1'b1, st: st, tvec: 32'h0, epc: epc,
              is_mret: 1'b1, e_cause: 32'h0, e_tval: 32'h0, e_epc: 32'h0,
              e_status: e_status, e_redir: e_redir, e_lat: 3};
        return r;
    endfunction

    // Called at a falling edge with the DUT idle; pulse injects ignored requests while busy
    task automatic apply_row(input row_t r, input bit pulse);
        int d_tick;
        int rc0;
        ld_en           = 1'b1;
        ld_status       = r.st;
        ld_tvec         = r.tvec;
        ld_epc          = r.epc;
        bus.exc_valid   = r.exc_valid;
        bus.exc_cause   = r.exc_cause;
        bus.exc_tval    = r.tval;
        bus.pc_in       = r.pc;
        bus.irq_ext     = r.irqs[2];
        bus.irq_soft    = r.irqs[1];
        bus.irq_timer   = r.irqs[0];
        bus.mie_mask    = r.mask;
        bus.mstatus_mie = r.mie;
        bus.mret        = r.mret;
        bus.boundary    = 1'b1;
        if (!r.is_mret) begin
            sb.push_back('{addr: 12'h341, data: r.e_epc, redir: 1'b0});
            sb.push_back('{addr: 12'h342, data: r.e_cause, redir: 1'b0});
            sb.push_back('{addr: 12'h343, data: r.e_tval, redir: 1'b0});
        end
        sb.push_back('{addr: 12'h300, data: r.e_status, redir: 1'b0});
        sb.push_back('{addr: 12'h000, data: r.e_redir, redir: 1'b1});
        d_tick = ticks;
        rc0 = redir_cnt;
        @(posedge clk);
        #1 ld_en = 1'b0;
        for (int i = 0; i < 20 && redir_cnt == rc0; i++) begin
            tick();
            clear_inputs();
            if (pulse && ticks == d_tick + 2) begin
                bus.exc_valid   = 1'b1;
                bus.exc_cause   = 4'h5;
                bus.mret        = 1'b1;
                bus.irq_ext     = 1'b1;
                bus.mie_mask    = 3'b111;
                bus.mstatus_mie = 1'b1;
                bus.boundary    = 1'b1;
            end
        end
        if (redir_cnt == rc0)
            chk("redirect_timeout", 32'h0, 32'h1);
        else
            chk("latency", redir_tick - d_tick, r.e_lat);
        tick();
        chk("idle_after_redirect", {31'h0, bus.busy}, 32'h0);
        chk("scoreboard_drained", sb.size(), 32'h0);
        sb.delete();
    endtask

    initial begin
        rst   = 1'b1;
        ld_en = 1'b0;
        ld_status = 32'h0;
        ld_tvec   = 32'h0;
        ld_epc    = 32'h0;
        clear_inputs();

        rows.push_back(exc_row(4'h2, 32'h0000_DEAD, 32'h100, 3'b000, 3'b000, 1'b0, 1'b0,
                               32'h8, 32'h200, 32'h1880, 32'h200));
        rows.push_back(irq_row(3'b001, 3'b010, 32'h1004, 32'h8, 32'h201,
                               32'h8000_0007, 32'h1880, 32'h21C));
        rows.push_back(exc_row(4'hB, 32'h55, 32'h2002, 3'b111, 3'b111, 1'b1, 1'b0,
                               32'h88, 32'h201, 32'h1880, 32'h200));
        rows.push_back(irq_row(3'b111, 3'b111, 32'h3000, 32'h8, 32'h201,
                               32'h8000_000B, 32'h1880, 32'h22C));
        rows.push_back(irq_row(3'b011, 3'b011, 32'h4008, 32'hFFFF_FFFF, 32'h1001,
                               32'h8000_0003, 32'hFFFF_FFF7, 32'h100C));
        rows.push_back(exc_row(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 3'b000, 1'b0, 1'b0,
                               32'h0, 32'h8003, 32'h1800, 32'h8000));
        rows.push_back(irq_row(3'b101, 3'b010, 32'h88, 32'h80, 32'h1,
                               32'h8000_0007, 32'h1800, 32'h1C));
        rows.push_back(mret_row(32'h1880, 32'h403, 32'h1888, 32'h400));
        rows.push_back(mret_row(32'h0, 32'hABCD_0002, 32'h1880, 32'hABCD_0000));
        rows.push_back(exc_row(4'h0, 32'h1234, 32'h500, 3'b000, 3'b000, 1'b0, 1'b1,
                               32'h1888, 32'h204, 32'h1880, 32'h204));

        tick();
        tick();
        chk("reset_busy", {31'h0, bus.busy}, 32'h0);
        chk("reset_redirect_valid", {31'h0, bus.redirect_valid}, 32'h0);
        chk("reset_csr_we_addr", {19'h0, bus.csr_we, bus.csr_addr}, 32'h0);
        chk("reset_csr_wdata", bus.csr_wdata, 32'h0);
        chk("reset_redirect_pc", bus.redirect_pc, 32'h0);
        rst = 1'b0;
        tick();

        foreach (rows[i]) apply_row(rows[i], 1'b0);

        // Requests raised mid-sequence must neither disturb nor queue behind it
        apply_row(rows[0], 1'b1);

        // Interrupt gated by global enable, then by instruction boundary
        bus.irq_soft    = 1'b1;
        bus.mie_mask    = 3'b001;
        bus.mstatus_mie = 1'b0;
        bus.boundary    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gated_by_mie_busy", {31'h0, bus.busy}, 32'h0);
        end
        bus.mstatus_mie = 1'b1;
        bus.boundary    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gated_by_boundary_busy", {31'h0, bus.busy}, 32'h0);
        end
        apply_row(irq_row(3'b010, 3'b001, 32'h600, 32'h8, 32'h301,
                          32'h8000_0003, 32'h1880, 32'h30C), 1'b0);

        // Reset asserted while in W_CAUSE
        ld_en         = 1'b1;
        ld_status     = 32'h8;
        ld_tvec       = 32'h200;
        ld_epc        = 32'h0;
        bus.exc_valid = 1'b1;
        bus.exc_cause = 4'h2;
        bus.exc_tval  = 32'hDEAD;
        bus.pc_in     = 32'h100;
        sb.push_back('{addr: 12'h341, data: 32'h100, redir: 1'b0});
        @(posedge clk);
        #1 ld_en = 1'b0;
        tick();
        clear_inputs();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        chk("abort_csr_we", {31'h0, bus.csr_we}, 32'h0);
        chk("abort_csr_addr", {20'h0, bus.csr_addr}, 32'h0);
        chk("abort_redirect_valid", {31'h0, bus.redirect_valid}, 32'h0);
        chk("abort_sb_epc_written", sb.size(), 32'h0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        apply_row(rows[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
